// File: rtl/npu_stream_loader_if.sv
// npu_stream_loader_if: start/length control, config ROM port, NPU config/input FIFO pushes and host stream.
// master is the loader side, slave is the environment (host, ROM, NPU FIFOs).
interface npu_stream_loader_if #(
    parameter int ADDR_W = 11,
    parameter int CFG_W  = 26,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic              start;
    logic [ADDR_W-1:0] cfg_len;
    logic [CNT_W-1:0]  in_count;
    logic              busy;
    logic              done;
    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [CFG_W-1:0]  npu_config_data;
    logic              npu_config_fifo_write_enable;
    logic              npu_config_fifo_full;
    logic [DATA_W-1:0] src_data;
    logic              src_valid;
    logic              src_ready;
    logic [DATA_W-1:0] npu_input_data;
    logic              npu_input_fifo_write_enable;
    logic              npu_input_fifo_full;

    modport master (
        input  start, cfg_len, in_count, rom_data, npu_config_fifo_full,
               src_data, src_valid, npu_input_fifo_full,
        output busy, done, rom_en, rom_addr, npu_config_data, npu_config_fifo_write_enable,
               src_ready, npu_input_data, npu_input_fifo_write_enable
    );

    modport slave (
        output start, cfg_len, in_count, rom_data, npu_config_fifo_full,
               src_data, src_valid, npu_input_fifo_full,
        input  busy, done, rom_en, rom_addr, npu_config_data, npu_config_fifo_write_enable,
               src_ready, npu_input_data, npu_input_fifo_write_enable
    );
endinterface

// File: rtl/npu_stream_loader.sv
// npu_stream_loader: streams cfg_len ROM words into the NPU config FIFO, then forwards in_count host words.
// A 2-entry skid buffer absorbs the one-cycle ROM latency so config pushes sustain one word per cycle.
module npu_stream_loader #(
    parameter int ADDR_W = 11,
    parameter int CFG_W  = 26,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input logic CLK,
    input logic RST_n,
    npu_stream_loader_if.master bus
);
    typedef enum logic [1:0] {IDLE, CFG, DATA, FIN} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] len, issued, pushed, addr_q;
    logic [CNT_W-1:0]  remaining;
    logic [DATA_W-1:0] fifo_q [2];
    logic              head, pend, pop, rd, ready, xfer;
    logic [1:0]        occ, level;

    always_comb begin
        pop   = state == CFG && occ != 2'd0 && !bus.npu_config_fifo_full;
        // level is next occupancy: in-flight read lands, a pop this cycle frees a slot
        level = occ + {1'b0, pend} - {1'b0, pop};
        rd    = state == CFG && issued < len && level < 2'd2;
        ready = state == DATA && remaining != '0 && !bus.npu_input_fifo_full;
        xfer  = ready && bus.src_valid;
        state_nx = state == IDLE ? (bus.start ? CFG : IDLE) :
                   state == CFG  ? (pushed == len && occ == 2'd0 && !pend ? DATA : CFG) :
                   state == DATA ? (remaining == '0 ? FIN : DATA) : IDLE;
        bus.busy                         = state == CFG || state == DATA;
        bus.done                         = state == FIN;
        bus.rom_en                       = rd;
        bus.rom_addr                     = addr_q;
        bus.npu_config_data              = fifo_q[head][CFG_W-1:0];
        bus.npu_config_fifo_write_enable = pop;
        bus.src_ready                    = ready;
        bus.npu_input_data               = state == DATA ? bus.src_data : '0;
        bus.npu_input_fifo_write_enable  = xfer;
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state     <= IDLE;
            len       <= '0;
            issued    <= '0;
            pushed    <= '0;
            addr_q    <= '0;
            remaining <= '0;
            pend      <= 1'b0;
            occ       <= 2'd0;
            head      <= 1'b0;
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && bus.start) begin
                len       <= bus.cfg_len;
                remaining <= bus.in_count;
                issued    <= '0;
                pushed    <= '0;
                addr_q    <= '0;
                pend      <= 1'b0;
                occ       <= 2'd0;
                head      <= 1'b0;
            end else begin
                pend <= rd;
                occ  <= level;
                if (rd) begin
                    issued <= issued + 1'b1;
                    addr_q <= addr_q + 1'b1;
                end
                // write slot is head+occ of the current entries, independent of a same-cycle pop
                if (pend) fifo_q[head ^ occ[0]] <= bus.rom_data;
                if (pop) begin
                    head   <= ~head;
                    pushed <= pushed + 1'b1;
                end
                if (xfer) remaining <= remaining - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_npu_stream_loader.sv
// tb_npu_stream_loader: directed scenarios for the loader with a synchronous ROM model and push monitors.
// ROM[i] carries i in its low bits and a fixed pattern above CFG_W so discarded upper bits are visible.
module tb_npu_stream_loader;
    logic CLK = 1'b0;
    logic RST_n = 1'b0;
    always #5 CLK = ~CLK;

    npu_stream_loader_if b();
    npu_stream_loader dut (.CLK(CLK), .RST_n(RST_n), .bus(b));

    int errors = 0, checks = 0, cyc = 0, start_cyc = 0;
    int rom_n = 0, done_n = 0, done_cyc = 0, stall_en = 0, sz = 0, n0 = 0, rel = 0;
    logic [31:0] cfg_q[$], in_q[$];
    int cfg_cyc[$];
    logic first_seen = 1'b0;
    logic [10:0] first_addr = '1;
    logic [11:0] vt = 12'b0011_1101_1100;
    logic [11:0] ft = 12'b0000_0001_1000;
    logic [11:0] rt = 12'b0000_1110_0110;
    int ein[4] = '{2, 3, 3, 3};
    int tin[3] = '{32'h102, 32'h106, 32'h107};

    always @(posedge CLK) cyc <= cyc + 1;
    always @(posedge CLK) if (b.rom_en) b.rom_data <= {6'h2d, 15'd0, b.rom_addr};

    always @(negedge CLK) if (RST_n) begin
        if (b.npu_config_fifo_write_enable) begin
            cfg_q.push_back(32'(b.npu_config_data));
            cfg_cyc.push_back(cyc);
        end
        if (b.npu_input_fifo_write_enable) in_q.push_back(b.npu_input_data);
        if (b.rom_en) begin
            rom_n++;
            if (b.npu_config_fifo_full) stall_en++;
            if (!first_seen) begin
                first_seen = 1'b1;
                first_addr = b.rom_addr;
            end
        end
        if (b.done) begin
            done_n++;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic go(input int len, input int cnt);
        b.cfg_len = 11'(len);
        b.in_count = 16'(cnt);
        b.start = 1'b1;
        step(1);
        b.start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_done(input string tag, input int base, input int lim);
        for (int t = 0; t < lim && done_n == base; t++) step(1);
        chk(tag, 64'(done_n - base), 64'd1);
    endtask

    task automatic clear_logs();
        cfg_q.delete();
        cfg_cyc.delete();
        in_q.delete();
        rom_n = 0;
        stall_en = 0;
    endtask

    function automatic int bad_seq(input int n);
        int k = (cfg_q.size() != n) ? 1 : 0;
        for (int i = 0; i < n && i < cfg_q.size(); i++) if (cfg_q[i] !== 32'(i)) k++;
        return k;
    endfunction

    initial begin
        b.start = 1'b0;
        b.cfg_len = '0;
        b.in_count = '0;
        b.npu_config_fifo_full = 1'b0;
        b.npu_input_fifo_full = 1'b0;
        b.src_valid = 1'b1;
        b.src_data = 32'hdead_beef;
        step(2);
        chk("reset ctrl", {b.busy, b.done, b.rom_en, b.npu_config_fifo_write_enable, b.src_ready,
                           b.npu_input_fifo_write_enable, b.rom_addr}, 64'd0);
        chk("reset data", {b.npu_config_data, b.npu_input_data}, 64'd0);
        RST_n = 1'b1;
        step(1);

        // basic run, with an extra start mid-run that must be ignored
        clear_logs();
        b.src_data = 32'd2;
        go(145, 4);
        chk("basic busy", b.busy, 1);
        step(3);
        b.start = 1'b1;
        b.cfg_len = 11'd3;
        b.in_count = 16'd9;
        step(1);
        b.start = 1'b0;
        for (int t = 0; t < 400 && in_q.size() == 0; t++) step(1);
        b.src_data = 32'd3;
        wait_done("basic done", 0, 400);
        b.src_valid = 1'b0;
        chk("basic cfg order", bad_seq(145), 0);
        chk("basic first push", 64'(cfg_cyc[0] - start_cyc), 64'd2);
        chk("basic back-to-back", 64'(cfg_cyc[cfg_q.size()-1] - cfg_cyc[0]), 64'd144);
        chk("basic rom reads", rom_n, 145);
        chk("basic in count", in_q.size(), 4);
        for (int i = 0; i < 4; i++) chk("basic in word", in_q[i], 64'(ein[i]));
        chk("basic done count", done_n, 1);
        chk("basic busy after", b.busy, 0);

        // config backpressure on cycles 3..7 after start
        clear_logs();
        n0 = done_n;
        go(8, 0);
        for (int t = 0; t < 60 && done_n == n0; t++) begin
            rel = cyc - start_cyc;
            b.npu_config_fifo_full = rel >= 3 && rel <= 7;
            if (rel == 8) chk("bp reads before stall", rom_n, 3);
            step(1);
        end
        b.npu_config_fifo_full = 1'b0;
        chk("bp done", 64'(done_n - n0), 64'd1);
        chk("bp cfg order", bad_seq(8), 0);
        chk("bp no read while full", stall_en, 0);
        chk("bp rom reads", rom_n, 8);

        // full toggling every cycle
        clear_logs();
        n0 = done_n;
        go(16, 0);
        for (int t = 0; t < 100 && done_n == n0; t++) begin
            b.npu_config_fifo_full = cyc[0];
            step(1);
        end
        b.npu_config_fifo_full = 1'b0;
        chk("alt done", 64'(done_n - n0), 64'd1);
        chk("alt cfg order", bad_seq(16), 0);
        chk("alt rom_addr end", b.rom_addr, 16);
        chk("alt rom reads", rom_n, 16);

        // zero lengths; start during FIN is ignored
        clear_logs();
        n0 = done_n;
        go(0, 0);
        chk("zero busy", b.busy, 1);
        step(2);
        chk("zero done in fin", b.done, 1);
        b.start = 1'b1;
        b.cfg_len = 11'd5;
        step(1);
        b.start = 1'b0;
        chk("zero busy after fin", b.busy, 0);
        step(2);
        chk("zero start in fin ignored", b.busy, 0);
        chk("zero rom reads", rom_n, 0);
        chk("zero pushes", cfg_q.size() + in_q.size(), 0);
        chk("zero done count", 64'(done_n - n0), 64'd1);
        chk("zero done latency", 64'(done_cyc - start_cyc), 64'd2);

        // input handshake with gapped valid and two full cycles
        clear_logs();
        n0 = done_n;
        go(0, 3);
        for (int r = 0; r < 12; r++) begin
            b.src_valid = vt[r];
            b.npu_input_fifo_full = ft[r];
            b.src_data = 32'h100 + 32'(r);
            #1;
            chk("hs src_ready", b.src_ready, 64'(rt[r]));
            step(1);
        end
        b.src_valid = 1'b0;
        b.npu_input_fifo_full = 1'b0;
        chk("hs in count", in_q.size(), 3);
        for (int i = 0; i < 3; i++) chk("hs in word", in_q[i], 64'(tin[i]));
        chk("hs done count", 64'(done_n - n0), 64'd1);
        chk("hs done latency", 64'(done_cyc - start_cyc), 64'd9);

        // reset during CFG after 10 pushes
        clear_logs();
        go(20, 0);
        for (int t = 0; t < 100 && cfg_q.size() < 10; t++) step(1);
        RST_n = 1'b0;
        #1;
        chk("rst ctrl", {b.busy, b.done, b.rom_en, b.npu_config_fifo_write_enable, b.src_ready,
                         b.npu_input_fifo_write_enable, b.rom_addr}, 64'd0);
        chk("rst data", {b.npu_config_data, b.npu_input_data}, 64'd0);
        sz = cfg_q.size();
        n0 = done_n;
        step(2);
        RST_n = 1'b1;
        step(3);
        chk("rst pushes frozen", cfg_q.size(), 10);
        chk("rst pushes before", sz, 10);
        chk("rst no done", done_n, n0);
        clear_logs();
        first_seen = 1'b0;
        go(3, 0);
        wait_done("rst rerun done", n0, 50);
        chk("rst rerun first addr", first_addr, 0);
        chk("rst rerun cfg order", bad_seq(3), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
